// File: rtl/serial_vector_fifo.sv
// Serial-to-parallel ring buffer: packs one bit per cycle into VEC_WIDTH-bit vectors,
// stores up to DEPTH of them and returns one per request with a registered response.
module serial_vector_fifo #(
    parameter int VEC_WIDTH = 8,
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_bit,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         req,
    output logic [VEC_WIDTH-1:0]         out_vector,
    output logic                         out_valid,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(VEC_WIDTH)-1:0] fill,
    output logic                         empty,
    output logic                         full,
    output logic                         overrun,
    output logic                         underrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(VEC_WIDTH);

    logic [VEC_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [VEC_WIDTH-1:0] shreg_q, shreg_d;
    logic [VEC_WIDTH-1:0] out_vector_q, out_vector_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 underrun_q, underrun_d;

    logic                 accept, complete, dequeue, mem_we;
    logic [VEC_WIDTH-1:0] shreg_next;

    assign in_ready   = (count_q < CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;
    assign fill       = fill_q;
    assign out_vector = out_vector_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

    always_comb begin
        if (MSB_FIRST) shreg_next = {shreg_q[VEC_WIDTH-2:0], in_bit};
        else           shreg_next = {in_bit, shreg_q[VEC_WIDTH-1:1]};
    end

    assign accept   = in_valid & in_ready;
    assign complete = accept && (fill_q == FW'(VEC_WIDTH - 1));
    // Dequeue uses registered count, so a vector completing this edge is not yet readable.
    assign dequeue  = req & ~empty;
    assign mem_we   = rst_n & ~flush & complete;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fill_d       = fill_q;
        shreg_d      = shreg_q;
        out_vector_d = '0;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;
        underrun_d   = underrun_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fill_d     = '0;
            shreg_d    = '0;
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end else begin
            if (accept) begin
                shreg_d = shreg_next;
                fill_d  = complete ? '0 : fill_q + FW'(1);
            end
            if (complete) wr_ptr_d = wr_ptr_q + PW'(1);
            if (in_valid && !in_ready) overrun_d = 1'b1;
            if (dequeue) begin
                out_vector_d = mem_q[rd_ptr_q];
                out_valid_d  = 1'b1;
                rd_ptr_d     = rd_ptr_q + PW'(1);
            end else if (req) begin
                underrun_d = 1'b1;
            end
            count_d = count_q + CW'(complete) - CW'(dequeue);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fill_q       <= '0;
            shreg_q      <= '0;
            out_vector_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fill_q       <= fill_d;
            shreg_q      <= shreg_d;
            out_vector_q <= out_vector_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= shreg_next;
    end

endmodule

// File: tb/tb_serial_vector_fifo.sv
// Testbench for serial_vector_fifo: one MSB-first and one LSB-first instance share stimulus
// and are compared against a queue-based reference model.
module tb_serial_vector_fifo;

    localparam int VW = 8;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_n, in_bit, in_valid, req, flush;

    logic          in_ready_a, out_valid_a, empty_a, full_a, overrun_a, underrun_a;
    logic [VW-1:0] out_vector_a;
    logic [3:0]    count_a;
    logic [2:0]    fill_a;
    logic          in_ready_b, out_valid_b, empty_b, full_b, overrun_b, underrun_b;
    logic [VW-1:0] out_vector_b;
    logic [3:0]    count_b;
    logic [2:0]    fill_b;

    serial_vector_fifo #(.VEC_WIDTH(VW), .DEPTH(D), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_a),
        .req(req), .out_vector(out_vector_a), .out_valid(out_valid_a), .flush(flush),
        .count(count_a), .fill(fill_a), .empty(empty_a), .full(full_a),
        .overrun(overrun_a), .underrun(underrun_a));

    serial_vector_fifo #(.VEC_WIDTH(VW), .DEPTH(D), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_b),
        .req(req), .out_vector(out_vector_b), .out_valid(out_valid_b), .flush(flush),
        .count(count_b), .fill(fill_b), .empty(empty_b), .full(full_b),
        .overrun(overrun_b), .underrun(underrun_b));

    always #5 clk = ~clk;

    // Reference model: stored vectors are kept in MSB-first order; LSB-first is the bit reversal.
    logic [VW-1:0] m_q[$];
    int            m_bits;
    logic [VW-1:0] m_part;
    logic          m_over, m_under, m_valid;
    logic [VW-1:0] m_vec;

    int tests_run = 0;
    int failures  = 0;

    function automatic logic [VW-1:0] rev(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < VW; i++) r[i] = v[VW-1-i];
        return r;
    endfunction

    task automatic step(input logic iv, input logic ib, input logic rq, input logic fl, input logic rn);
        int            cnt;
        logic          comp;
        logic [VW-1:0] newvec;
        in_valid = iv; in_bit = ib; req = rq; flush = fl; rst_n = rn;
        @(posedge clk);
        if (!rn || fl) begin
            m_q.delete();
            m_bits = 0; m_part = '0; m_over = 0; m_under = 0; m_valid = 0; m_vec = '0;
        end else begin
            cnt    = m_q.size();
            comp   = 0;
            newvec = '0;
            if (iv && cnt < D) begin
                m_part = (m_part << 1) | VW'(ib);
                m_bits++;
                if (m_bits == VW) begin
                    comp = 1; newvec = m_part; m_bits = 0; m_part = '0;
                end
            end
            if (iv && cnt >= D) m_over = 1;
            if (rq && cnt != 0) begin
                m_vec = m_q.pop_front(); m_valid = 1;
            end else begin
                m_vec = '0; m_valid = 0;
                if (rq) m_under = 1;
            end
            if (comp) m_q.push_back(newvec);
        end
        #1;
    endtask

    task automatic send_vec(input logic [VW-1:0] v, input logic req_on_last);
        for (int i = VW - 1; i >= 0; i--) step(1'b1, v[i], req_on_last && (i == 0), 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++; if (count_a !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", count_a); end
        tests_run++; if (fill_a !== 3'd0) begin failures++; $display("[TB] FAIL reset_fill got %0d want 0", fill_a); end
        tests_run++; if ({empty_a, full_a, in_ready_a} !== 3'b101) begin failures++; $display("[TB] FAIL reset_status got %b want 101", {empty_a, full_a, in_ready_a}); end
        tests_run++; if ({out_valid_a, overrun_a, underrun_a, out_vector_a} !== '0) begin failures++; $display("[TB] FAIL reset_outputs got %b_%b_%b_%h want all 0", out_valid_a, overrun_a, underrun_a, out_vector_a); end
    endtask

    task automatic test_serial_order();
        send_vec(8'b1011_0010, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tests_run++; if (out_valid_a !== 1'b1 || out_vector_a !== 8'hB2) begin failures++; $display("[TB] FAIL serial_msb got %b/%h want 1/b2", out_valid_a, out_vector_a); end
        tests_run++; if (out_valid_b !== 1'b1 || out_vector_b !== 8'h4D) begin failures++; $display("[TB] FAIL serial_lsb got %b/%h want 1/4d", out_valid_b, out_vector_b); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++; if (out_valid_a !== 1'b0 || out_vector_a !== 8'h00) begin failures++; $display("[TB] FAIL serial_one_cycle got %b/%h want 0/00", out_valid_a, out_vector_a); end
        tests_run++; if (empty_a !== 1'b1 || count_a !== 4'd0) begin failures++; $display("[TB] FAIL serial_empty got %b/%0d want 1/0", empty_a, count_a); end
    endtask

    task automatic test_full_backpressure();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < VW * D; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1);
        tests_run++; if (full_a !== 1'b1 || in_ready_a !== 1'b0 || count_a !== 4'd8) begin failures++; $display("[TB] FAIL full_status got full=%b ready=%b count=%0d want 1/0/8", full_a, in_ready_a, count_a); end
        tests_run++; if (overrun_a !== 1'b0) begin failures++; $display("[TB] FAIL full_no_overrun got %b want 0", overrun_a); end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tests_run++; if (overrun_a !== 1'b1 || fill_a !== 3'd0) begin failures++; $display("[TB] FAIL full_overrun got ovr=%b fill=%0d want 1/0", overrun_a, fill_a); end
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            tests_run++; if (out_valid_a !== 1'b1 || out_vector_a !== m_vec) begin failures++; $display("[TB] FAIL full_drain%0d got %b/%h want 1/%h", i, out_valid_a, out_vector_a, m_vec); end
            tests_run++; if (out_vector_b !== rev(m_vec)) begin failures++; $display("[TB] FAIL full_drain_lsb%0d got %h want %h", i, out_vector_b, rev(m_vec)); end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tests_run++; if (out_valid_a !== 1'b0 || underrun_a !== 1'b1) begin failures++; $display("[TB] FAIL full_underrun got valid=%b und=%b want 0/1", out_valid_a, underrun_a); end
    endtask

    task automatic test_wrap_around();
        int e = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int v = 0; v < 3; v++) send_vec(VW'(v), 1'b0);
        for (int v = 3; v < 20; v++) begin
            send_vec(VW'(v), 1'b1);
            tests_run++; if (out_valid_a !== 1'b1 || out_vector_a !== VW'(e)) begin failures++; $display("[TB] FAIL wrap_vec got %b/%0d want 1/%0d", out_valid_a, out_vector_a, e); end
            tests_run++; if (count_a !== 4'd3) begin failures++; $display("[TB] FAIL wrap_count got %0d want 3", count_a); end
            e++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            tests_run++; if (out_valid_a !== 1'b1 || out_vector_a !== VW'(e)) begin failures++; $display("[TB] FAIL wrap_drain got %b/%0d want 1/%0d", out_valid_a, out_vector_a, e); end
            e++;
        end
        tests_run++; if (empty_a !== 1'b1 || underrun_a !== 1'b0) begin failures++; $display("[TB] FAIL wrap_end got empty=%b und=%b want 1/0", empty_a, underrun_a); end
    endtask

    task automatic test_simultaneous();
        logic [VW-1:0] first, last;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        first = VW'($urandom);
        send_vec(first, 1'b0);
        send_vec(VW'($urandom), 1'b0);
        send_vec(VW'($urandom), 1'b0);
        last = VW'($urandom);
        for (int i = VW - 1; i >= 1; i--) step(1'b1, last[i], 1'b0, 1'b0, 1'b1);
        step(1'b1, last[0], 1'b1, 1'b0, 1'b1);
        tests_run++; if (count_a !== 4'd3) begin failures++; $display("[TB] FAIL simul_count got %0d want 3", count_a); end
        tests_run++; if (out_valid_a !== 1'b1 || out_vector_a !== first) begin failures++; $display("[TB] FAIL simul_oldest got %b/%h want 1/%h", out_valid_a, out_vector_a, first); end
        // A vector completing on the same edge as a request to an empty buffer is not returned.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = VW - 1; i >= 1; i--) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tests_run++; if (out_valid_a !== 1'b0 || underrun_a !== 1'b1 || count_a !== 4'd1) begin failures++; $display("[TB] FAIL simul_empty got valid=%b und=%b count=%0d want 0/1/1", out_valid_a, underrun_a, count_a); end
    endtask

    task automatic test_flush_reset(input bit use_reset);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_vec(VW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tests_run++; if (count_a !== 4'd4 || fill_a !== 3'd3 || underrun_a !== 1'b1) begin failures++; $display("[TB] FAIL clear%0d_pre got count=%0d fill=%0d und=%b want 4/3/1", use_reset, count_a, fill_a, underrun_a); end
        send_vec(VW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        if (use_reset) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        else           step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tests_run++; if (count_a !== 4'd0 || fill_a !== 3'd0 || empty_a !== 1'b1) begin failures++; $display("[TB] FAIL clear%0d_state got count=%0d fill=%0d empty=%b want 0/0/1", use_reset, count_a, fill_a, empty_a); end
        tests_run++; if ({out_valid_a, overrun_a, underrun_a, out_vector_a} !== '0) begin failures++; $display("[TB] FAIL clear%0d_outputs got %b_%b_%b_%h want all 0", use_reset, out_valid_a, overrun_a, underrun_a, out_vector_a); end
        send_vec(8'h5A, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tests_run++; if (out_valid_a !== 1'b1 || out_vector_a !== 8'h5A || out_vector_b !== 8'h5A) begin failures++; $display("[TB] FAIL clear%0d_readback got %b/%h/%h want 1/5a/5a", use_reset, out_valid_a, out_vector_a, out_vector_b); end
    endtask

    task automatic test_random();
        logic iv, rq, fl;
        int   sz;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            iv = ($urandom_range(0, 3) != 0);
            rq = ((c / 250) % 2 == 0) ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 399) == 0);
            step(iv, 1'($urandom), rq, fl, 1'b1);
            sz = m_q.size();
            tests_run++; if (out_valid_a !== m_valid || out_vector_a !== m_vec) begin failures++; $display("[TB] FAIL rand_out c=%0d got %b/%h want %b/%h", c, out_valid_a, out_vector_a, m_valid, m_vec); end
            tests_run++; if (out_vector_b !== rev(m_vec)) begin failures++; $display("[TB] FAIL rand_out_lsb c=%0d got %h want %h", c, out_vector_b, rev(m_vec)); end
            tests_run++; if (count_a !== 4'(sz) || fill_a !== 3'(m_bits)) begin failures++; $display("[TB] FAIL rand_count c=%0d got %0d/%0d want %0d/%0d", c, count_a, fill_a, sz, m_bits); end
            tests_run++; if ({in_ready_a, empty_a, full_a} !== {sz < D, sz == 0, sz == D}) begin failures++; $display("[TB] FAIL rand_status c=%0d got %b want %b", c, {in_ready_a, empty_a, full_a}, {sz < D, sz == 0, sz == D}); end
            tests_run++; if ({overrun_a, underrun_a} !== {m_over, m_under}) begin failures++; $display("[TB] FAIL rand_flags c=%0d got %b want %b", c, {overrun_a, underrun_a}, {m_over, m_under}); end
            tests_run++; if ({in_ready_b, empty_b, full_b, overrun_b, underrun_b, out_valid_b, count_b, fill_b} !==
                             {sz < D, sz == 0, sz == D, m_over, m_under, m_valid, 4'(sz), 3'(m_bits)}) begin
                failures++; $display("[TB] FAIL rand_lsb_status c=%0d got %b/%0d/%0d", c, {in_ready_b, empty_b, full_b, overrun_b, underrun_b, out_valid_b}, count_b, fill_b);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; req = 1'b0; flush = 1'b0;
        m_bits = 0; m_part = '0; m_over = 0; m_under = 0; m_valid = 0; m_vec = '0;
        test_reset();
        test_serial_order();
        test_full_backpressure();
        test_wrap_around();
        test_simultaneous();
        test_flush_reset(1'b0);
        test_flush_reset(1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
